cr_xp10_decomp_sdd_buf_ctl: RTL and testbench

- Bit-buffer controller for the SDD (symbol decode) front end.
- Owns the N-word circular bit buffer between the LFA word input and the lane decoder.
- Writes incoming 32-bit words into the buffer and schedules decode launches (buffer index, word index mod 8, valid bit count).
- Retires consumed bits from the selector's LFA ack bus (numbits/eob/err) and flushes on block end or error.

---
 rtl/cr_xp10_decomp_sdd_buf_ctl.sv | 205 ++++++++++++++++++++
 tb/tb_cr_xp10_decomp_sdd_buf_ctl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cr_xp10_decomp_sdd_buf_ctl.sv
// SDD bit-buffer controller: circular word-buffer writes, decode launch scheduling, ack-driven bit retirement.
// Optional saturating statistics outputs are enabled by defining CR_XP10_SDD_BUF_CTL_STATS_EN.
module cr_xp10_decomp_sdd_buf_ctl #(
  parameter int unsigned N_WORDS     = 8,
  parameter int unsigned LAUNCH_BITS = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_data,
  input  logic                       in_sob,
  input  logic                       in_eof,
  output logic                       buf_we,
  output logic [$clog2(N_WORDS)-1:0] buf_waddr,
  output logic [31:0]                buf_wdata,
  output logic                       ld_valid,
  input  logic                       ld_ready,
  output logic [$clog2(N_WORDS)-1:0] ld_buf_idx,
  output logic [2:0]                 ld_word_mod_8,
  output logic [4:0]                 ld_bit_off,
  output logic [9:0]                 ld_numbits,
  output logic                       ld_sob,
  output logic                       ld_eof,
  input  logic                       ack_valid,
  input  logic [6:0]                 ack_numbits,
  input  logic                       ack_eob,
  input  logic                       ack_err,
  output logic                       flush_active
`ifdef CR_XP10_SDD_BUF_CTL_STATS_EN
  ,
  output logic [31:0]                stat_frames,
  output logic [15:0]                stat_err_frames,
  output logic [31:0]                stat_flush_words
`endif
);

  localparam int unsigned AW = $clog2(N_WORDS);
  localparam int unsigned WW = AW + 1;
  localparam int unsigned RW = WW + 5;
  localparam int unsigned CW = (RW > 11) ? RW : 11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    FLUSH_ERR = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [WW-1:0] wr_ptr;
  logic [WW-1:0] wr_n;
  logic [WW-1:0] occ;
  logic [WW-1:0] occ_n;
  logic [RW-1:0] rd_ptr;
  logic [RW-1:0] rd_n;
  logic [RW-1:0] rd_sum;
  logic [RW-1:0] avail_n;
  logic [CW-1:0] avail_w;
  logic          eof_seen;
  logic          eof_n;
  logic          launch_pend;
  logic          pend_n;
  logic          sob_arm;
  logic          sob_n;
  logic          hs;
  logic          ack_take;
  logic          ld_hs;
  logic          hold;
  logic          go_n;

  // Write side: occupancy from current pointers, discard in FLUSH_ERR and for non-sob words in IDLE.
  assign occ       = wr_ptr - rd_ptr[RW-1:5];
  assign in_ready  = (state == FLUSH_ERR) || ((occ != WW'(N_WORDS)) && !eof_seen);
  assign hs        = in_valid && in_ready;
  assign buf_we    = hs && ((state == RUN) || ((state == IDLE) && in_sob));
  assign buf_waddr = wr_ptr[AW-1:0];
  assign buf_wdata = in_data;

  assign ack_take = ack_valid && launch_pend && (state == RUN);
  assign ld_hs    = ld_valid && ld_ready;
  assign hold     = ld_valid && !ld_ready;
  assign rd_sum   = rd_ptr + RW'(ack_numbits);

  // Next pointer/state values; launch decisions use these so a write at t is visible at t+1.
  always_comb begin
    state_n = state;
    wr_n    = wr_ptr + WW'(buf_we);
    rd_n    = rd_ptr;
    eof_n   = eof_seen || (buf_we && in_eof);
    pend_n  = launch_pend;
    sob_n   = sob_arm;

    if (ld_hs) begin
      pend_n = 1'b1;
      sob_n  = 1'b0;
    end

    case (state)
      IDLE: begin
        if (hs && in_sob) begin
          state_n = RUN;
          sob_n   = 1'b1;
        end
      end
      RUN: begin
        if (ack_take) begin
          pend_n = 1'b0;
          if (ack_err) begin
            rd_n    = {wr_n, 5'b0};
            eof_n   = 1'b0;
            state_n = (eof_seen || (buf_we && in_eof)) ? IDLE : FLUSH_ERR;
          end else if (ack_eob && eof_seen) begin
            rd_n    = {wr_n, 5'b0};
            eof_n   = 1'b0;
            state_n = IDLE;
          end else if (ack_eob) begin
            rd_n = {rd_sum[RW-1:5] + WW'(|rd_sum[4:0]), 5'b0};
          end else begin
            rd_n = rd_sum;
          end
        end
      end
      FLUSH_ERR: begin
        if (hs && in_eof) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    occ_n   = wr_n - rd_n[RW-1:5];
    avail_n = {occ_n, 5'b0} - RW'(rd_n[4:0]);
    avail_w = CW'(avail_n);
    go_n    = (state_n == RUN) && !pend_n &&
              ((avail_w >= CW'(LAUNCH_BITS)) || (eof_n && (avail_n != '0)));
  end

  // State, pointers and registered launch request; a pending launch is frozen until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      eof_seen      <= 1'b0;
      launch_pend   <= 1'b0;
      sob_arm       <= 1'b0;
      flush_active  <= 1'b0;
      ld_valid      <= 1'b0;
      ld_buf_idx    <= '0;
      ld_word_mod_8 <= '0;
      ld_bit_off    <= '0;
      ld_numbits    <= '0;
      ld_sob        <= 1'b0;
      ld_eof        <= 1'b0;
    end else begin
      state        <= state_n;
      wr_ptr       <= wr_n;
      rd_ptr       <= rd_n;
      eof_seen     <= eof_n;
      launch_pend  <= pend_n;
      sob_arm      <= sob_n;
      flush_active <= (state_n == FLUSH_ERR);
      if (!hold) begin
        ld_valid <= go_n;
        if (go_n) begin
          ld_buf_idx    <= rd_n[5 +: AW];
          ld_word_mod_8 <= rd_n[7:5];
          ld_bit_off    <= rd_n[4:0];
          ld_numbits    <= (avail_w > CW'(256)) ? 10'd256 : avail_w[9:0];
          ld_sob        <= sob_n;
          ld_eof        <= eof_n;
        end
      end
    end
  end

  // An ack is only meaningful against an outstanding launch; stray acks are ignored above.
  ack_without_launch: assert property (@(posedge clk) disable iff (!rst_n)
    ack_valid |-> (launch_pend && (state == RUN)));

`ifdef CR_XP10_SDD_BUF_CTL_STATS_EN
  // Saturating counters: eof-completed frames, decode errors, discarded words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames      <= '0;
      stat_err_frames  <= '0;
      stat_flush_words <= '0;
    end else begin
      if ((state == RUN) && (state_n == IDLE) && (stat_frames != '1)) begin
        stat_frames <= stat_frames + 32'd1;
      end
      if (ack_take && ack_err && (stat_err_frames != '1)) begin
        stat_err_frames <= stat_err_frames + 16'd1;
      end
      if (hs && !buf_we && (stat_flush_words != '1)) begin
        stat_flush_words <= stat_flush_words + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cr_xp10_decomp_sdd_buf_ctl.sv
// Bench for cr_xp10_decomp_sdd_buf_ctl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a model that tracks absolute word/bit counts.
module tb_cr_xp10_decomp_sdd_buf_ctl;

  localparam int NW = 8;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_sob = 1'b0;
  logic        in_eof = 1'b0;
  logic        buf_we;
  logic [2:0]  buf_waddr;
  logic [31:0] buf_wdata;
  logic        ld_valid;
  logic        ld_ready = 1'b0;
  logic [2:0]  ld_buf_idx;
  logic [2:0]  ld_word_mod_8;
  logic [4:0]  ld_bit_off;
  logic [9:0]  ld_numbits;
  logic        ld_sob;
  logic        ld_eof;
  logic        ack_valid = 1'b0;
  logic [6:0]  ack_numbits = '0;
  logic        ack_eob = 1'b0;
  logic        ack_err = 1'b0;
  logic        flush_active;

  always #5 clk = ~clk;

  cr_xp10_decomp_sdd_buf_ctl #(.N_WORDS(NW), .LAUNCH_BITS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sob(in_sob), .in_eof(in_eof),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_buf_idx(ld_buf_idx), .ld_word_mod_8(ld_word_mod_8),
    .ld_bit_off(ld_bit_off), .ld_numbits(ld_numbits), .ld_sob(ld_sob), .ld_eof(ld_eof),
    .ack_valid(ack_valid), .ack_numbits(ack_numbits), .ack_eob(ack_eob), .ack_err(ack_err),
    .flush_active(flush_active)
  );

  int checks = 0;
  int errors = 0;

  // Model: absolute words written and absolute bits retired, plus the expected launch register.
  int m_mode, m_wr, m_rd, m_idx, m_mod8, m_off, m_nb;
  bit m_eof, m_pend, m_sobarm, m_ldv, m_lsob, m_leof;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = M_IDLE; m_wr = 0; m_rd = 0; m_eof = 0; m_pend = 0; m_sobarm = 0;
    m_ldv = 0; m_idx = 0; m_mod8 = 0; m_off = 0; m_nb = 0; m_lsob = 0; m_leof = 0;
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model, check registered outputs.
  task automatic step(input bit v, input logic [31:0] d, input bit s, input bit e, input bit r,
                      input bit av, input int n, input bit eb, input bit er);
    int  occ, avl;
    bit  rdy, hs, we, eof_old, ldhs;
    in_valid = v; in_data = d; in_sob = s; in_eof = e; ld_ready = r;
    ack_valid = av; ack_numbits = 7'(n); ack_eob = eb; ack_err = er;
    #1;
    occ = m_wr - m_rd / 32;
    rdy = (m_mode == M_FLUSH) || (occ != NW && !m_eof);
    hs  = v && rdy;
    we  = hs && (m_mode == M_RUN || (m_mode == M_IDLE && s));
    cmp("in_ready", int'(in_ready), int'(rdy));
    cmp("buf_we", int'(buf_we), int'(we));
    if (we) begin
      cmp("buf_waddr", int'(buf_waddr), m_wr % NW);
      cmp("buf_wdata", int'(buf_wdata == d), 1);
    end

    eof_old = m_eof;
    ldhs = m_ldv && r;
    if (we) m_wr++;
    if (we && e) m_eof = 1;
    if (ldhs) begin m_pend = 1; m_sobarm = 0; end
    if (m_mode == M_IDLE) begin
      if (hs && s) begin m_mode = M_RUN; m_sobarm = 1; end
    end else if (m_mode == M_RUN) begin
      if (av && !ldhs) begin
        m_pend = 0;
        if (er) begin
          m_rd = m_wr * 32;
          m_mode = (eof_old || (we && e)) ? M_IDLE : M_FLUSH;
          m_eof = 0;
        end else if (eb && eof_old) begin
          m_rd = m_wr * 32; m_eof = 0; m_mode = M_IDLE;
        end else if (eb) begin
          m_rd = ((m_rd + n + 31) / 32) * 32;
        end else begin
          m_rd = m_rd + n;
        end
      end
    end else begin
      if (hs && e) m_mode = M_IDLE;
    end
    if (!(m_ldv && !r)) begin
      avl = m_wr * 32 - m_rd;
      m_ldv = (m_mode == M_RUN) && !m_pend && (avl >= 64 || (m_eof && avl > 0));
      if (m_ldv) begin
        m_idx = (m_rd / 32) % NW; m_mod8 = (m_rd / 32) % 8; m_off = m_rd % 32;
        m_nb = (avl > 256) ? 256 : avl; m_lsob = m_sobarm; m_leof = m_eof;
      end
    end

    @(posedge clk);
    @(negedge clk);
    cmp("ld_valid", int'(ld_valid), int'(m_ldv));
    cmp("flush_active", int'(flush_active), int'(m_mode == M_FLUSH));
    if (m_ldv) begin
      cmp("ld_buf_idx", int'(ld_buf_idx), m_idx);
      cmp("ld_word_mod_8", int'(ld_word_mod_8), m_mod8);
      cmp("ld_bit_off", int'(ld_bit_off), m_off);
      cmp("ld_numbits", int'(ld_numbits), m_nb);
      cmp("ld_sob", int'(ld_sob), int'(m_lsob));
      cmp("ld_eof", int'(ld_eof), int'(m_leof));
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_sob = 0; in_eof = 0; ld_ready = 0;
    ack_valid = 0; ack_numbits = '0; ack_eob = 0; ack_err = 0;
  endtask

  initial begin
    m_reset();
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("rst_ld_valid", int'(ld_valid), 0);
    cmp("rst_in_ready", int'(in_ready), 1);
    cmp("rst_flush", int'(flush_active), 0);
    cmp("rst_numbits", int'(ld_numbits), 0);

    // sob + one word: 64 bits available, launch visible the cycle after the second write.
    step(1, 32'hA000_0000, 1, 0, 0, 0, 0, 0, 0);
    step(1, 32'hA000_0001, 0, 0, 0, 0, 0, 0, 0);
    cmp("first_ld_valid", int'(ld_valid), 1);
    cmp("first_buf_idx", int'(ld_buf_idx), 0);
    cmp("first_bit_off", int'(ld_bit_off), 0);
    cmp("first_numbits", int'(ld_numbits), 64);
    cmp("first_sob", int'(ld_sob), 1);

    // Fill to 8 words without acks; the held launch keeps its 64-bit snapshot.
    for (int i = 2; i < 8; i++) step(1, 32'hA000_0000 + 32'(i), 0, 0, 0, 0, 0, 0, 0);
    cmp("full_in_ready", int'(in_ready), 0);
    cmp("held_numbits", int'(ld_numbits), 64);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cmp("taken_ld_valid", int'(ld_valid), 0);
    step(0, 0, 0, 0, 0, 1, 40, 0, 0);
    cmp("reopen_in_ready", int'(in_ready), 1);
    cmp("ack40_ld_valid", int'(ld_valid), 1);
    cmp("ack40_bit_off", int'(ld_bit_off), 8);
    cmp("ack40_buf_idx", int'(ld_buf_idx), 1);
    cmp("ack40_numbits", int'(ld_numbits), 216);
    cmp("ack40_sob", int'(ld_sob), 0);

    // Deflate block end at bit offset 13 rounds up to word 2.
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 5, 1, 0);
    cmp("eob_bit_off", int'(ld_bit_off), 0);
    cmp("eob_buf_idx", int'(ld_buf_idx), 2);
    cmp("eob_mod8", int'(ld_word_mod_8), 2);
    cmp("eob_numbits", int'(ld_numbits), 192);

    // Error before eof: flush, discard 4 words, eof word returns to IDLE, new frame at word 8.
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 1);
    cmp("err_flush_active", int'(flush_active), 1);
    for (int i = 0; i < 4; i++) step(1, 32'hDEAD_0000 + 32'(i), 0, 0, 0, 0, 0, 0, 0);
    cmp("flush_in_ready", int'(in_ready), 1);
    step(1, 32'hDEAD_00FF, 0, 1, 0, 0, 0, 0, 0);
    cmp("flush_done", int'(flush_active), 0);
    step(1, 32'hB000_0000, 1, 0, 0, 0, 0, 0, 0);
    step(1, 32'hB000_0001, 0, 0, 0, 0, 0, 0, 0);
    cmp("restart_ld_valid", int'(ld_valid), 1);
    cmp("restart_buf_idx", int'(ld_buf_idx), 0);
    cmp("restart_sob", int'(ld_sob), 1);

    // Random traffic: frames, acks bounded by available bits, occasional eob/err; pointers wrap many times.
    for (int c = 0; c < 4000; c++) begin
      bit v, s, e, r, av, eb, er;
      int n, avl, mx;
      v = ($urandom % 4) != 0;
      s = (m_mode == M_IDLE) ? (($urandom % 4) != 0) : (($urandom % 16) == 0);
      e = (m_mode == M_FLUSH) ? (($urandom % 4) == 0) : (($urandom % 10) == 0);
      r = ($urandom % 3) != 0;
      av = 0; n = 0; eb = 0; er = 0;
      if (m_pend && ($urandom % 3) == 0) begin
        avl = m_wr * 32 - m_rd;
        mx = (avl < 96) ? avl : 96;
        n = int'($urandom_range(mx, 0));
        av = 1;
        er = ($urandom % 40) == 0;
        if (!er) eb = m_eof ? (n == avl || ($urandom % 8) == 0) : (($urandom % 20) == 0);
      end
      step(v, $urandom, s, e, r, av, n, eb, er);
    end

    // Asynchronous reset mid-frame empties the buffer and returns to IDLE.
    step(1, 32'hC000_0000, 1, 0, 0, 0, 0, 0, 0);
    idle_inputs();
    #2 rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("mid_rst_ld_valid", int'(ld_valid), 0);
    cmp("mid_rst_in_ready", int'(in_ready), 1);
    cmp("mid_rst_flush", int'(flush_active), 0);
    step(1, 32'hC100_0000, 1, 0, 0, 0, 0, 0, 0);
    step(1, 32'hC100_0001, 0, 0, 0, 0, 0, 0, 0);
    cmp("post_rst_buf_idx", int'(ld_buf_idx), 0);
    cmp("post_rst_numbits", int'(ld_numbits), 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
